// File: rtl/t_latch_pkg.sv
// t_latch_pkg
// Shared constants for the toggle-latch slice: default width and the
// default per-bit value loaded into the held state by reset.
package t_latch_pkg;

   localparam int   DEFAULT_WIDTH   = 1;
   localparam logic DEFAULT_RST_BIT = 1'b0;

endpackage

// File: rtl/t_latch_if.sv
// t_latch_if
// Bundles the toggle request and the true/complement outputs of a toggle
// latch. The master side drives t and observes q/qbar; the slave side is
// the latch itself.
interface t_latch_if
   import t_latch_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;

   modport master (
      output t,
      input  q,
      input  qbar
   );

   modport slave (
      input  t,
      output q,
      output qbar
   );

endinterface

// File: rtl/t_latch_bit.sv
// t_latch_bit
// Single-bit level-sensitive toggle latch.
// While clk is high the output shows the held value inverted by t, purely
// combinationally, and the held value itself does not move. When clk falls
// the toggled value is committed, so a request that is still high at the
// falling transition produces exactly one net inversion and a request that
// was withdrawn before the fall leaves the state untouched.
// The held value is kept as a pair of opposite-phase latches: r_mid tracks
// the candidate value while clk is high and freezes at the fall, r_hold
// takes that frozen value while clk is low. Splitting it this way is what
// prevents the held value from chasing its own inversion (oscillation)
// while t is asserted. No clk edge flip-flops are used anywhere.
module t_latch_bit
   import t_latch_pkg::*;
#(
   parameter logic RST_VAL = DEFAULT_RST_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q,
   output logic qbar
);

   logic r_mid;
   logic r_hold;
   logic w_q;

   // Candidate latch: open while clk is high, follows held value XOR t.
   always_latch begin
      if (!rst) begin
         r_mid <= RST_VAL;
      end else if (clk) begin
         r_mid <= r_hold ^ t;
      end
   end

   // Held-value latch: open while clk is low, commits the frozen candidate.
   always_latch begin
      if (!rst) begin
         r_hold <= RST_VAL;
      end else if (!clk) begin
         r_hold <= r_mid;
      end
   end

   // Output: reset value under reset, toggle window while clk high, hold otherwise.
   assign w_q  = !rst ? RST_VAL : (clk ? (r_hold ^ t) : r_hold);
   assign q    = w_q;
   assign qbar = ~w_q;

endmodule

// File: rtl/t_latch.sv
// t_latch
// WIDTH-bit toggle latch built from independent single-bit cells. Each bit
// has its own reset value taken from RST_VAL; bits never interact.
module t_latch
   import t_latch_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEFAULT_RST_BIT}}
) (
   input  logic      clk,
   input  logic      rst,
   t_latch_if.slave  bus
);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_qbar;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_latch_bit #(
         .RST_VAL (RST_VAL[i])
      ) u_bit (
         .clk  (clk),
         .rst  (rst),
         .t    (bus.t[i]),
         .q    (w_q[i]),
         .qbar (w_qbar[i])
      );
   end

   assign bus.q    = w_q;
   assign bus.qbar = w_qbar;

endmodule

// File: tb/tb_t_latch.sv
// tb_t_latch
// Scoreboard bench for the toggle latch. A 4-bit instance is driven step by
// step (directed then random) and a reference model based on per-bit toggle
// counts predicts q. A free-running master/slave pair of 1-bit instances is
// checked against a reference T flip-flop for the master state and for
// q/qbar complementarity on both halves.
module tb_t_latch;
   import t_latch_pkg::*;

   localparam int         MAIN_W      = 4;
   localparam logic [3:0] MAIN_RST    = 4'b1001;
   localparam int         PAIR_CYCLES = 60;

   int assertCount = 0;
   int failCount   = 0;

   // Main instance
   logic mClk = 1'b0;
   logic mRst = 1'b0;
   t_latch_if #(.WIDTH(MAIN_W)) mainIf ();

   t_latch #(
      .WIDTH   (MAIN_W),
      .RST_VAL (MAIN_RST)
   ) u_dut (
      .clk (mClk),
      .rst (mRst),
      .bus (mainIf)
   );

   // Master/slave pair
   logic pairClk = 1'b0;
   logic pairClkN;
   logic pairRst = 1'b0;
   logic pairDone = 1'b0;
   t_latch_if #(.WIDTH(1)) pairMIf ();
   t_latch_if #(.WIDTH(1)) pairSIf ();

   assign pairClkN  = ~pairClk;
   assign pairSIf.t = pairMIf.q;

   t_latch #(.WIDTH(1), .RST_VAL(1'b0)) u_master (
      .clk (pairClk),
      .rst (pairRst),
      .bus (pairMIf)
   );

   t_latch #(.WIDTH(1), .RST_VAL(1'b0)) u_slave (
      .clk (pairClkN),
      .rst (pairRst),
      .bus (pairSIf)
   );

   always #10 pairClk = ~pairClk;

   // Reference model state for the main instance
   logic       curClk = 1'b0;
   logic       curRst = 1'b0;
   logic [3:0] curT   = 4'b0000;
   int         toggleCount [MAIN_W];

   logic [3:0] expQ [$];
   string      nameQ [$];
   event       mainEv;

   logic       pairExpQ [$];
   event       pairEv;
   logic       pairTff = 1'b0;

   function automatic logic [3:0] modelQ();
      logic [3:0] held;
      for (int b = 0; b < MAIN_W; b++) begin
         held[b] = MAIN_RST[b] ^ toggleCount[b][0];
      end
      if (!curRst) return MAIN_RST;
      return curClk ? (held ^ curT) : held;
   endfunction

   task automatic checkOutput(input string name, input logic [3:0] actual,
                              input logic [3:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one set of inputs, advance the model, enqueue the prediction.
   task automatic applyStimulus(input logic clkV, input logic rstV,
                                input logic [3:0] tV, input string name);
      if (!rstV) begin
         for (int b = 0; b < MAIN_W; b++) toggleCount[b] = 0;
      end else if (curRst && curClk && !clkV) begin
         for (int b = 0; b < MAIN_W; b++) toggleCount[b] += int'(curT[b]);
      end
      curClk = clkV;
      curRst = rstV;
      curT   = tV;
      mClk      = clkV;
      mRst      = rstV;
      mainIf.t  = tV;
      #1;
      expQ.push_back(modelQ());
      nameQ.push_back(name);
      -> mainEv;
      #1;
   endtask

   // Main monitor: pops a prediction each time a sample is presented.
   initial begin
      logic [3:0] e;
      string      n;
      forever begin
         @(mainEv);
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL main_queue: got empty queue expected a prediction");
         end else begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput(n, mainIf.q, e);
            checkOutput({n, "_qbar"}, mainIf.qbar, ~e);
         end
      end
   end

   // Main stimulus: directed scenarios followed by random steps.
   initial begin
      logic [3:0] rt;
      int         sel;
      for (int b = 0; b < MAIN_W; b++) toggleCount[b] = 0;
      mainIf.t = 4'b0000;
      #1;
      applyStimulus(1'b0, 1'b0, 4'b0000, "reset_idle");
      applyStimulus(1'b0, 1'b0, 4'b1111, "reset_t_high");
      applyStimulus(1'b1, 1'b0, 4'b1111, "reset_clk_hi");
      applyStimulus(1'b0, 1'b0, 4'b1111, "reset_clk_lo");
      applyStimulus(1'b1, 1'b0, 4'b1111, "reset_clk_hi2");
      applyStimulus(1'b0, 1'b0, 4'b1111, "reset_clk_lo2");
      applyStimulus(1'b0, 1'b1, 4'b1111, "release_lo");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 4'b0000 : 4'b1111, "opaque_hold");
      end
      applyStimulus(1'b0, 1'b1, 4'b0110, "opaque_pre");
      applyStimulus(1'b1, 1'b1, 4'b0110, "toggle_rise");
      applyStimulus(1'b1, 1'b1, 4'b0110, "toggle_hold");
      applyStimulus(1'b0, 1'b1, 4'b0110, "toggle_fall");
      applyStimulus(1'b0, 1'b1, 4'b0000, "after_fall_t0");
      applyStimulus(1'b1, 1'b1, 4'b0000, "next_hi_t0");
      applyStimulus(1'b1, 1'b1, 4'b1111, "pulse_on");
      applyStimulus(1'b1, 1'b1, 4'b0000, "pulse_off");
      applyStimulus(1'b0, 1'b1, 4'b0000, "pulse_fall");
      applyStimulus(1'b0, 1'b1, 4'b1111, "mid_pre");
      applyStimulus(1'b1, 1'b1, 4'b1111, "mid_rise");
      applyStimulus(1'b1, 1'b0, 4'b1111, "mid_reset");
      applyStimulus(1'b1, 1'b1, 4'b1111, "release_hi");
      applyStimulus(1'b0, 1'b1, 4'b1111, "release_hi_fall");
      applyStimulus(1'b1, 1'b1, 4'b1111, "sim_rise");
      applyStimulus(1'b0, 1'b0, 4'b1111, "sim_fall_reset");
      applyStimulus(1'b0, 1'b1, 4'b1111, "sim_release");
      for (int i = 0; i < 300; i++) begin
         sel = int'($urandom_range(0, 15));
         if (sel < 6) begin
            rt = 4'($urandom_range(0, 15));
            applyStimulus(curClk, curRst, rt, "rand_t");
         end else if (sel < 14) begin
            applyStimulus(~curClk, curRst, curT, "rand_clk");
         end else begin
            applyStimulus(curClk, ~curRst, curT, "rand_rst");
         end
      end
      if (!curRst) applyStimulus(curClk, 1'b1, curT, "final_release");

      for (int i = 0; i < 10000 && !pairDone; i++) #1;
      assertCount++;
      if (!pairDone) begin
         failCount++;
         $display("[TB] FAIL pair_timeout: got pairDone=0 expected 1");
      end
      #5;
      assertCount++;
      if (expQ.size() != 0 || pairExpQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", expQ.size(), pairExpQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Pair toggle request: changes every 13 units, kept away from clock edges.
   initial begin
      pairMIf.t = 1'b0;
      while (!pairDone) begin
         #13;
         if ((($time % 10) == 0) || (($time % 10) == 1)) #2;
         pairMIf.t = 1'($urandom_range(0, 1));
      end
   end

   // Pair producer: reference T flip-flop toggles on t at master close.
   initial begin
      #2;
      pairExpQ.push_back(1'b0);
      -> pairEv;
      #3;
      pairRst = 1'b1;
      for (int c = 0; c < PAIR_CYCLES; c++) begin
         @(posedge pairClk);
         pairExpQ.push_back(pairTff ^ pairMIf.t);
         #1;
         -> pairEv;
         @(negedge pairClk);
         pairTff = pairTff ^ pairMIf.t;
         pairExpQ.push_back(pairTff);
         #1;
         -> pairEv;
      end
      pairDone = 1'b1;
   end

   // Pair monitor: master against T flip-flop, both halves complementary.
   initial begin
      logic e;
      forever begin
         @(pairEv);
         if (pairExpQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL pair_queue: got empty queue expected a prediction");
         end else begin
            e = pairExpQ.pop_front();
            checkOutput("pair_master_q", {3'b000, pairMIf.q}, {3'b000, e});
            checkOutput("pair_master_qbar", {3'b000, pairMIf.qbar}, {3'b000, ~e});
            assertCount++;
            if ($isunknown(pairSIf.q) || (pairSIf.qbar !== ~pairSIf.q)) begin
               failCount++;
               $display("[TB] FAIL pair_slave_compl: got q=%b qbar=%b expected complementary",
                        pairSIf.q, pairSIf.qbar);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/t_latch.md
Name: t_latch

Overview:
- Level-sensitive toggle (T) latch, WIDTH bits wide. Each bit is independent.
- Primitive storage cell for master-slave toggle flip-flops. Two instances are used: one on clk, one on ~clk, with the first instance's q feeding the second instance's t.
- Provides true and complementary outputs.
- Asynchronous active-low reset clears the state.

Parameters:
- WIDTH, 1, number of independent toggle-latch bits.
- RST_VAL, 0 (WIDTH bits), value loaded into the stored state by reset.

Ports:
- clk  input  1  latch enable. Transparent (toggle window) while high, opaque while low.
- rst  input  1  asynchronous active-low reset. 0 = reset asserted.
- t  input  WIDTH  per-bit toggle request.
- q  output  WIDTH  latch output.
- qbar  output  WIDTH  bitwise complement of q at all times.

Behaviour:
- State per bit: held value H, an internal storage element.
- Reset, rst=0:
  - H is forced to RST_VAL immediately, independent of clk and t.
  - q=RST_VAL and qbar=~RST_VAL for the whole time rst is low.
  - Reset dominates every other input.
- Release of reset, rst 0->1:
  - No output change at release; H keeps RST_VAL.
  - If clk is already high at release, the toggle rule below applies from that instant.
- Opaque phase, clk=0, rst=1:
  - q=H, qbar=~H.
  - t is ignored.
  - H does not change.
- Transparent phase, clk=1, rst=1:
  - q = H XOR t, purely combinational from t. qbar = ~q.
  - H does not change during the phase.
  - Result: t=1 gives exactly one inversion relative to the phase-entry value, never oscillation. A t pulse that returns to 0 before clk falls leaves q=H.
- Closing edge, clk 1->0 with rst=1:
  - H captures H XOR t, sampled at the falling transition. This is the net toggle.
  - q stays continuous across the edge, with no glitch.
- Simultaneous clk fall and rst fall: reset wins, H=RST_VAL.
- qbar is never X when q is known. At power-up before any reset, q and qbar are unspecified; benches must assert rst first.
- Zero latency: q responds combinationally to t, clk and rst. No internal clocked pipeline.
- Bits are fully independent. WIDTH=1 is the primary use.
- Implementation:
  - H is a level-sensitive storage element with a transparent-low update of H XOR t, plus asynchronous clear.
  - No flip-flops on clk edges.
  - Synthesis must infer latches only for H.
  - Lint waivers for intentional latches are permitted.

Decomposition:
- Shared package: none required. Optionally a localparam for the default reset value, in the team's common constants package, if one exists.
- Natural sub-module: t_latch_bit, a single-bit cell with ports clk, rst, t, q, qbar and the RST_VAL bit.
- t_latch instantiates WIDTH copies of t_latch_bit via generate.

Test Plan:
- Reset: rst=0, clk toggling, t=1 -> q=0, qbar=1 throughout; no toggles during reset.
- Opaque hold: rst=1, clk=0, t toggles 0/1 repeatedly -> q stays 0, qbar stays 1.
- Single toggle: H=0, clk rises with t=1 -> q=1 immediately, stays 1 for the whole high phase, no oscillation. clk falls -> q remains 1. Next high phase with t=0 -> q=1.
- Transient t: H=1, clk high, t pulses 0->1->0 before clk falls -> q goes 1->0->1; after clk falls q=1 (H unchanged).
- Async reset mid-phase: clk=1, t=1, q=1, rst falls -> q=0 and qbar=1 within the same timestep. rst rises with clk=1, t=1 -> q=1.
- Master-slave pair (two instances, second on ~clk with t=q of first): clk period 20, t random every 13 time units, rst low 0-5 -> q and qbar always complementary; after reset, Q toggles only where t was 1 at master close. Compare against a reference T-flip-flop model.
